ripple_carry_adder_core: RTL and testbench



---
 rtl/ripple_carry_adder_core.sv | 104 ++++++++++
 tb/tb_ripple_carry_adder_core.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/ripple_carry_adder_core.sv
// ----------------------------------------------------------------------------
// ripple_carry_adder_core
//   WIDTH-bit ripple-carry adder built from per-bit full-adder cells.
//   A one-cycle output register with a valid flag sits on the chain.
//   Computes {C_out, sum} = a + b + c_in, unsigned, modulo 2^(WIDTH+1).
//
//   Optional feature: define RCA_OVERFLOW_EN to add the registered output
//   'ovf'. It is the signed two's-complement overflow, c[WIDTH] ^ c[WIDTH-1].
//   With the macro undefined, the ovf port does not exist.
//
//   Reset is synchronous and active-low (rst_n), sampled on the rising edge
//   of clk. Legal WIDTH range is 1..64.
// ----------------------------------------------------------------------------

// Single full-adder cell: one link of the ripple chain.
module rca_full_adder (
    input  logic i_a,
    input  logic i_b,
    input  logic i_c,
    output logic o_s,
    output logic o_c
);
    logic w_p;

    assign w_p = i_a ^ i_b;
    assign o_s = w_p ^ i_c;
    assign o_c = (i_a & i_b) | (i_c & w_p);
endmodule

module ripple_carry_adder_core #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic [WIDTH-1:0] sum,
    output logic             C_out,
`ifdef RCA_OVERFLOW_EN
    output logic             ovf,
`endif
    output logic             out_valid
);

    // Carry vector: w_carry[0] is the carry-in, w_carry[WIDTH] is the carry-out.
    logic [WIDTH:0]   w_carry;
    logic [WIDTH-1:0] w_sum;

    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
    logic             r_valid;
`ifdef RCA_OVERFLOW_EN
    logic             r_ovf;
`endif

    assign w_carry[0] = c_in;

    // Explicit per-bit chain, so each carry really ripples through every cell.
    for (genvar gi = 0; gi < int'(WIDTH); gi++) begin : g_bit
        rca_full_adder u_fa (
            .i_a (a[gi]),
            .i_b (b[gi]),
            .i_c (w_carry[gi]),
            .o_s (w_sum[gi]),
            .o_c (w_carry[gi+1])
        );
    end

    // Output stage: reset wins, otherwise capture on in_valid and hold otherwise.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking (<=) so every register samples
        // pre-edge values; blocking here would create order-dependent races.
        if (!rst_n) begin
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_valid <= 1'b0;
`ifdef RCA_OVERFLOW_EN
            r_ovf   <= 1'b0;
`endif
        end else begin
            r_valid <= in_valid;
            // NOTE: a missing else inside a clocked block is a clock-enable hold,
            // not a latch; the same pattern in always_comb would infer a latch.
            // Gating on in_valid also keeps X on idle inputs out of the held result.
            if (in_valid) begin
                r_sum  <= w_sum;
                r_cout <= w_carry[WIDTH];
`ifdef RCA_OVERFLOW_EN
                r_ovf  <= w_carry[WIDTH] ^ w_carry[WIDTH-1];
`endif
            end
        end
    end

    assign sum       = r_sum;
    assign C_out     = r_cout;
    assign out_valid = r_valid;
`ifdef RCA_OVERFLOW_EN
    assign ovf       = r_ovf;
`endif

endmodule

// File: tb/tb_ripple_carry_adder_core.sv
// ----------------------------------------------------------------------------
// tb_ripple_carry_adder_core
//   Directed-vector bench for ripple_carry_adder_core (WIDTH = 8).
//   Every expected value is hand-computed. Inputs are driven on the falling
//   edge, and outputs are sampled 1 ns after the rising edge.
//   Define RCA_OVERFLOW_EN for the bench and the RTL together to exercise ovf.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_ripple_carry_adder_core;

    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         c_in;
    logic [W-1:0] sum;
    logic         C_out;
    logic         out_valid;
`ifdef RCA_OVERFLOW_EN
    logic         ovf;
`endif

    int n_tests  = 0;
    int n_failed = 0;

    ripple_carry_adder_core #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
        .c_in      (c_in),
        .sum       (sum),
        .C_out     (C_out),
`ifdef RCA_OVERFLOW_EN
        .ovf       (ovf),
`endif
        .out_valid (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_failed++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, obs, obs, exp, exp);
        end
    endtask

    // Drive one cycle's inputs on the falling edge, then land 1 ns after the rising edge.
    task automatic drive(input logic v, input logic [W-1:0] ia, input logic [W-1:0] ib,
                         input logic ic);
        @(negedge clk);
        in_valid = v;
        a        = ia;
        b        = ib;
        c_in     = ic;
        @(posedge clk);
        #1;
    endtask

    // Check all three base outputs in one call.
    task automatic expect_out(input string tag, input logic [W-1:0] es, input logic ec,
                              input logic ev);
        check({tag, ".sum"},       64'(sum),       64'(es));
        check({tag, ".C_out"},     64'(C_out),     64'(ec));
        check({tag, ".out_valid"}, 64'(out_valid), 64'(ev));
    endtask

    logic [15:0] wide_a;

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b0;
        a        = '0;
        b        = '0;
        c_in     = 1'b0;

        // Reset held for two cycles while driving a valid vector: reset must win.
        drive(1'b1, 8'hFF, 8'h01, 1'b0);
        expect_out("rst0", 8'd0, 1'b0, 1'b0);
        drive(1'b1, 8'hFF, 8'h01, 1'b0);
        expect_out("rst1", 8'd0, 1'b0, 1'b0);
`ifdef RCA_OVERFLOW_EN
        check("rst1.ovf", 64'(ovf), 64'd0);
`endif

        // Back-to-back directed vectors; each result appears one edge later.
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b1, 8'd12, 8'd8, 1'b0);
        expect_out("v12_8", 8'd20, 1'b0, 1'b1);
        drive(1'b1, 8'd2, 8'd8, 1'b0);
        expect_out("v2_8", 8'd10, 1'b0, 1'b1);
        drive(1'b1, 8'd22, 8'd17, 1'b0);
        expect_out("v22_17", 8'd39, 1'b0, 1'b1);
        drive(1'b1, 8'd23, 8'd10, 1'b1);
        expect_out("v23_10_1", 8'd34, 1'b0, 1'b1);
        wide_a = 16'd602;
        drive(1'b1, wide_a[7:0], 8'd31, 1'b0);
        expect_out("v602trunc_31", 8'd121, 1'b0, 1'b1);
        drive(1'b1, 8'd2, 8'd8, 1'b1);
        expect_out("v2_8_1", 8'd11, 1'b0, 1'b1);

        // Carry boundaries.
        drive(1'b1, 8'd255, 8'd1, 1'b0);
        expect_out("wrap255_1", 8'd0, 1'b1, 1'b1);
        drive(1'b1, 8'd255, 8'd0, 1'b1);
        expect_out("wrap255_0_1", 8'd0, 1'b1, 1'b1);
        drive(1'b1, 8'd255, 8'd255, 1'b1);
        expect_out("max", 8'd255, 1'b1, 1'b1);
        drive(1'b1, 8'd128, 8'd128, 1'b0);
        expect_out("msb128", 8'd0, 1'b1, 1'b1);
`ifdef RCA_OVERFLOW_EN
        check("msb128.ovf", 64'(ovf), 64'd1);
`endif

        // Hold: register 20, then three idle cycles with random operands.
        drive(1'b1, 8'd12, 8'd8, 1'b0);
        expect_out("hold_load", 8'd20, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, W'($urandom), W'($urandom), 1'($urandom));
            expect_out($sformatf("hold%0d", i), 8'd20, 1'b0, 1'b0);
        end

        // Hold of a set carry: load 255+1, then idle.
        drive(1'b1, 8'd255, 8'd1, 1'b0);
        expect_out("holdc_load", 8'd0, 1'b1, 1'b1);
        drive(1'b0, 8'd3, 8'd4, 1'b0);
        expect_out("holdc", 8'd0, 1'b1, 1'b0);

        // Mid-stream reset: a valid 22+17 arrives on the same edge as the reset.
        drive(1'b1, 8'd5, 8'd6, 1'b0);
        expect_out("pre_rst", 8'd11, 1'b0, 1'b1);
        @(negedge clk);
        rst_n = 1'b0;
        drive(1'b1, 8'd22, 8'd17, 1'b0);
        expect_out("midrst", 8'd0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b1, 8'd23, 8'd10, 1'b1);
        expect_out("post_rst", 8'd34, 1'b0, 1'b1);

`ifdef RCA_OVERFLOW_EN
        // Signed overflow flag.
        drive(1'b1, 8'd127, 8'd1, 1'b0);
        expect_out("ovf127_1", 8'd128, 1'b0, 1'b1);
        check("ovf127_1.ovf", 64'(ovf), 64'd1);
        drive(1'b1, 8'd100, 8'd20, 1'b0);
        expect_out("ovf100_20", 8'd120, 1'b0, 1'b1);
        check("ovf100_20.ovf", 64'(ovf), 64'd0);
        drive(1'b1, 8'd128, 8'd128, 1'b0);
        expect_out("ovf128_128", 8'd0, 1'b1, 1'b1);
        check("ovf128_128.ovf", 64'(ovf), 64'd1);
        drive(1'b0, 8'd1, 8'd1, 1'b0);
        check("ovf_hold", 64'(ovf), 64'd1);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_failed);
        $finish;
    end

endmodule
